// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader FSM state encoding.
// Used by both the IMEM array side and the loader.
package imem_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_DEPTH     = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CHK   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Clamp a requested load length to the memory capacity.
  function automatic logic [6:0] sat_len(input logic [6:0] req, input logic [6:0] cap);
    return (req > cap) ? cap : req;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four bytes into a little-endian 32-bit word; byte k lands in lane k.
// word shows the assembly including the byte being pushed this cycle.
module byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        cnt_reg;
  logic [WORD_W-1:0] data_reg;

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word[gi*8 +: 8] = (push && cnt_reg == 2'(gi)) ? byte_in : data_reg[gi*8 +: 8];
    end
  endgenerate

  // Asserted on the push that completes a word; the counter wraps to lane 0 by itself.
  assign word_full = push && (cnt_reg == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg  <= 2'd0;
      data_reg <= '0;
    end else if (push) begin
      cnt_reg  <= cnt_reg + 2'd1;
      data_reg <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Packs a valid/ready byte stream into 32-bit words and writes them to IMEM from address 0.
// Optional trailing-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        load_words,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [6:0]        word_count,
  output logic              err
);

  localparam logic [6:0] DEPTH_CAP = 7'(DEPTH);

  logic [2:0]        state_reg;
  logic [6:0]        word_idx_reg;
  logic [6:0]        total_reg;
  logic [6:0]        word_count_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [WORD_W-1:0] wr_data_reg;
  logic [6:0]        total_next;
  logic              last_word;
  logic              push;
  logic              packer_clear;
  logic [WORD_W-1:0] packed_word;
  logic              word_full;

  assign total_next   = sat_len(load_words, DEPTH_CAP);
  assign last_word    = (word_idx_reg == total_reg - 7'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready     = (state_reg == ST_RECV) || (state_reg == ST_CHK);
`else
  assign in_ready     = (state_reg == ST_RECV);
`endif
  assign push         = in_valid && in_ready;
  assign packer_clear = (state_reg == ST_IDLE);

  assign wr_en      = (state_reg == ST_WRITE);
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign word_count = word_count_reg;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (packer_clear),
    .push      (push),
    .byte_in   (in_byte),
    .word      (packed_word),
    .word_full (word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] xor_reg;
  logic              err_reg;

  assign err = done && err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      xor_reg <= '0;
      err_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && start) begin
      xor_reg <= '0;
      err_reg <= 1'b0;
    end else if (state_reg == ST_RECV && word_full) begin
      xor_reg <= xor_reg ^ packed_word;
    end else if (state_reg == ST_CHK && word_full) begin
      err_reg <= (packed_word != xor_reg);
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      word_idx_reg   <= 7'd0;
      total_reg      <= 7'd0;
      word_count_reg <= 7'd0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            word_idx_reg   <= 7'd0;
            word_count_reg <= 7'd0;
            total_reg      <= total_next;
            state_reg      <= (total_next == 7'd0) ? ST_DONE : ST_RECV;
          end
        end
        ST_RECV: begin
          // Latch the completed word so the write cycle presents stable data.
          if (word_full) begin
            wr_addr_reg <= ADDR_W'({word_idx_reg, 2'b00});
            wr_data_reg <= packed_word;
            state_reg   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          word_count_reg <= word_idx_reg + 7'd1;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_reg <= ST_CHK;
`else
            state_reg <= ST_DONE;
`endif
          end else begin
            word_idx_reg <= word_idx_reg + 7'd1;
            state_reg    <= ST_RECV;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (word_full) state_reg <= ST_DONE;
        end
`endif
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, stalls, zero/saturated length, reset abort,
// and (with IMEM_LOADER_CHECKSUM_EN) the trailing checksum.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  load_words;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [6:0]  word_count;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_words (load_words),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .err        (err)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  stim_q[$];
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt;
  logic        err_at_done;
  logic        ready_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to the next falling edge and record what the DUT is showing there.
  task automatic tick();
    @(negedge clk);
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      err_at_done = err;
    end
    if (in_ready) ready_seen = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic clear_capture();
    wa_q.delete();
    wd_q.delete();
    done_cnt    = 0;
    err_at_done = 1'b0;
    ready_seen  = 1'b0;
  endtask

  // Start a load, feed stim_q (optionally with random gaps), then wait for done.
  task automatic run_load(input logic [6:0] n, input bit gaps, input bit wait_done);
    int idx;
    int cyc;
    bit xfer;
    clear_capture();
    start      = 1'b1;
    load_words = n;
    tick();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < stim_q.size() && cyc < stim_q.size() * 20 + 20) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_byte  = stim_q[idx];
      xfer     = in_valid && in_ready;
      tick();
      if (xfer) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
    check("feed_complete", 32'(idx), 32'(stim_q.size()));
    if (wait_done) begin
      cyc = 0;
      while (done_cnt == 0 && cyc < 20) begin
        tick();
        cyc++;
      end
      tick();
      tick();
      check("done_once", 32'(done_cnt), 32'd1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    load_words = 7'd0;
    in_valid   = 1'b0;
    in_byte    = 8'h00;
    clear_capture();
    tick();
    tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    rst = 1'b0;
    tick();

    // Two words, no stalls.
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(7'd2, 1'b0, 1'b1);
    check("t1_nwrites", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("t1_addr0", 32'(wa_q[0]), 32'h00);
      check("t1_data0", wd_q[0], 32'h00000013);
      check("t1_addr1", 32'(wa_q[1]), 32'h04);
      check("t1_data1", wd_q[1], 32'h00100093);
    end
    check("t1_word_count", 32'(word_count), 32'd2);
    check("t1_err", 32'(err_at_done), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Three words with random input gaps.
    stim_q.delete();
    push_word(32'h04030201);
    push_word(32'hDDCCBBAA);
    push_word(32'h12345678);
    run_load(7'd3, 1'b1, 1'b1);
    check("t2_nwrites", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      check("t2_addr0", 32'(wa_q[0]), 32'h00);
      check("t2_data0", wd_q[0], 32'h04030201);
      check("t2_addr1", 32'(wa_q[1]), 32'h04);
      check("t2_data1", wd_q[1], 32'hDDCCBBAA);
      check("t2_addr2", 32'(wa_q[2]), 32'h08);
      check("t2_data2", wd_q[2], 32'h12345678);
    end
    check("t2_word_count", 32'(word_count), 32'd3);

    // Zero-length load.
    stim_q.delete();
    run_load(7'd0, 1'b0, 1'b1);
    check("t3_nwrites", 32'(wa_q.size()), 32'd0);
    check("t3_ready_seen", 32'(ready_seen), 32'd0);
    check("t3_word_count", 32'(word_count), 32'd0);

    // Oversized request saturates to 64 words.
    stim_q.delete();
    for (int i = 0; i < 256; i++) stim_q.push_back(8'(i));
    run_load(7'd100, 1'b0, 1'b1);
    check("t4_nwrites", 32'(wa_q.size()), 32'd64);
    if (wa_q.size() == 64) begin
      check("t4_last_addr", 32'(wa_q[63]), 32'hFC);
      check("t4_last_data", wd_q[63], 32'hFFFEFDFC);
      check("t4_addr10", 32'(wa_q[10]), 32'h28);
    end
    check("t4_word_count", 32'(word_count), 32'd64);
    check("t4_in_ready_idle", 32'(in_ready), 32'd0);

    // Reset after two bytes of word 1 aborts the load.
    stim_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55, 8'h66};
    run_load(7'd2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t5_nwrites", 32'(wa_q.size()), 32'd1);
    check("t5_wr_addr", 32'(wr_addr), 32'd0);
    check("t5_wr_data", wr_data, 32'd0);
    check("t5_word_count", 32'(word_count), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done_cnt", 32'(done_cnt), 32'd0);
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(7'd2, 1'b0, 1'b1);
    check("t5_re_nwrites", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check("t5_re_addr0", 32'(wa_q[0]), 32'h00);
      check("t5_re_data0", wd_q[0], 32'h00000013);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.delete();
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    run_load(7'd2, 1'b0, 1'b1);
    check("t6_good_err", 32'(err_at_done), 32'd0);
    check("t6_good_nwrites", 32'(wa_q.size()), 32'd2);
    stim_q.delete();
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h00000000);
    run_load(7'd2, 1'b0, 1'b1);
    check("t6_bad_err", 32'(err_at_done), 32'd1);
    check("t6_bad_nwrites", 32'(wa_q.size()), 32'd2);
    stim_q.delete();
    run_load(7'd0, 1'b0, 1'b1);
    check("t6_zero_err", 32'(err_at_done), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
